// File: rtl/flexbex_clock_gate_ctrl.sv
// Core clock-gate controller: RUN -> DRAIN -> SLEEP -> WAKE sequencing of the core clock enable.
// Optional sleep-cycle statistics counter is compiled in with FLEXBEX_SLEEP_STATS_EN.
module flexbex_clock_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sleep_req_i,
    input  logic        core_busy_i,
    input  logic        irq_pending_i,
    input  logic        debug_req_i,
    input  logic        test_en_i,
    output logic        clock_en_o,
    output logic        core_sleep_o
`ifdef FLEXBEX_SLEEP_STATS_EN
    ,
    output logic [31:0] sleep_cycles_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

    state_e     state_reg;
    state_e     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       wake_evt;

    assign wake_evt = irq_pending_i | debug_req_i;

    // The counter is shared: idle-cycle count in DRAIN, elapsed wake cycles in WAKE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (sleep_req_i && !wake_evt) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                // Wake or withdrawn request beats a completing idle count.
                if (wake_evt || !sleep_req_i) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else if (cnt_reg == IDLE_LAST && !core_busy_i && !test_en_i) begin
                    state_next = ST_SLEEP;
                    cnt_next   = '0;
                end else if (core_busy_i) begin
                    cnt_next = '0;
                end else if (cnt_reg != IDLE_LAST) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_SLEEP: begin
                if (wake_evt) begin
                    state_next = ST_WAKE;
                    cnt_next   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt_reg == WAKE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state so they are a pure function of it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_RUN;
            cnt_reg      <= '0;
            clock_en_o   <= 1'b1;
            core_sleep_o <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clock_en_o   <= (state_next != ST_SLEEP);
            core_sleep_o <= (state_next == ST_SLEEP) || (state_next == ST_WAKE);
        end
    end

`ifdef FLEXBEX_SLEEP_STATS_EN
    logic [31:0] sleep_cycles_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sleep_cycles_reg <= '0;
        end else if (state_reg == ST_SLEEP && sleep_cycles_reg != 32'hFFFF_FFFF) begin
            sleep_cycles_reg <= sleep_cycles_reg + 32'd1;
        end
    end

    assign sleep_cycles_o = sleep_cycles_reg;
`endif

endmodule

// File: tb/tb_flexbex_clock_gate_ctrl.sv
// Bench for flexbex_clock_gate_ctrl: directed latency scenarios plus randomized traffic
// checked every cycle against a behavioural model of the sleep/wake rules.
module tb_flexbex_clock_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    localparam logic [1:0] M_RUN   = 2'd0;
    localparam logic [1:0] M_DRAIN = 2'd1;
    localparam logic [1:0] M_SLEEP = 2'd2;
    localparam logic [1:0] M_WAKE  = 2'd3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic sleep_req_i = 1'b0;
    logic core_busy_i = 1'b0;
    logic irq_pending_i = 1'b0;
    logic debug_req_i = 1'b0;
    logic test_en_i = 1'b0;
    logic clock_en_o;
    logic core_sleep_o;
`ifdef FLEXBEX_SLEEP_STATS_EN
    logic [31:0] sleep_cycles_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    flexbex_clock_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sleep_req_i   (sleep_req_i),
        .core_busy_i   (core_busy_i),
        .irq_pending_i (irq_pending_i),
        .debug_req_i   (debug_req_i),
        .test_en_i     (test_en_i),
        .clock_en_o    (clock_en_o),
        .core_sleep_o  (core_sleep_o)
`ifdef FLEXBEX_SLEEP_STATS_EN
        ,
        .sleep_cycles_o(sleep_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Model: idle_run counts consecutive non-busy drain cycles; wake_left counts down the wake window.
    typedef struct packed {
        logic [1:0]  mode;
        int          idle_run;
        int          wake_left;
        logic [31:0] stats;
    } model_t;

    model_t m = '{mode: M_RUN, idle_run: 0, wake_left: 0, stats: 32'd0};

    function automatic model_t model_step(model_t s, logic sreq, logic busy, logic wake, logic test);
        model_t n = s;
        if (s.mode == M_SLEEP && s.stats != 32'hFFFF_FFFF) n.stats = s.stats + 32'd1;
        case (s.mode)
            M_RUN: if (sreq && !wake) begin
                n.mode = M_DRAIN;
                n.idle_run = 0;
            end
            M_DRAIN: begin
                if (wake || !sreq) begin
                    n.mode = M_RUN;
                end else begin
                    n.idle_run = busy ? 0 : s.idle_run + 1;
                    if (n.idle_run >= IDLE_CYCLES && !test) n.mode = M_SLEEP;
                end
            end
            M_SLEEP: if (wake) begin
                n.mode = M_WAKE;
                n.wake_left = WAKE_CYCLES;
            end
            default: begin
                n.wake_left = s.wake_left - 1;
                if (n.wake_left == 0) n.mode = M_RUN;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m <= '{mode: M_RUN, idle_run: 0, wake_left: 0, stats: 32'd0};
        else m <= model_step(m, sleep_req_i, core_busy_i, irq_pending_i | debug_req_i, test_en_i);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        check("model_clock_en", 32'(clock_en_o), 32'(m.mode != M_SLEEP));
        check("model_core_sleep", 32'(core_sleep_o), 32'(m.mode == M_SLEEP || m.mode == M_WAKE));
`ifdef FLEXBEX_SLEEP_STATS_EN
        check("model_sleep_cycles", sleep_cycles_o, m.stats);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        sleep_req_i = 0; core_busy_i = 0; irq_pending_i = 0; debug_req_i = 0; test_en_i = 0;
        rst_ni = 0;
        step(2);
        rst_ni = 1;
    endtask

    initial begin
        // Reset state
        step(2);
        check("reset_clock_en", 32'(clock_en_o), 32'd1);
        check("reset_core_sleep", 32'(core_sleep_o), 32'd0);
        rst_ni = 1;
        $display("reset: clock_en=%0b core_sleep=%0b", clock_en_o, core_sleep_o);

        // Idle entry then irq wake
        sleep_req_i = 1;
        step(4);
        check("entry_c4_clock_en", 32'(clock_en_o), 32'd1);
        step(1);
        check("entry_c5_clock_en", 32'(clock_en_o), 32'd0);
        check("entry_c5_core_sleep", 32'(core_sleep_o), 32'd1);
        irq_pending_i = 1;
        step(1);
        irq_pending_i = 0;
        check("wake_k1_clock_en", 32'(clock_en_o), 32'd1);
        check("wake_k1_core_sleep", 32'(core_sleep_o), 32'd1);
        step(1);
        check("wake_k2_core_sleep", 32'(core_sleep_o), 32'd1);
        step(1);
        check("wake_k3_core_sleep", 32'(core_sleep_o), 32'd0);
        check("wake_k3_clock_en", 32'(clock_en_o), 32'd1);
        $display("idle entry + wake: core_sleep=%0b at k+3", core_sleep_o);

        // Busy restart in the third drain cycle
        do_reset();
        sleep_req_i = 1;
        step(3);
        core_busy_i = 1;
        step(1);
        core_busy_i = 0;
        step(3);
        check("busy_c7_clock_en", 32'(clock_en_o), 32'd1);
        step(1);
        check("busy_c8_clock_en", 32'(clock_en_o), 32'd0);
        $display("busy restart: clock_en=%0b at cycle 8", clock_en_o);

        // Debug request coincides with drain completion
        do_reset();
        sleep_req_i = 1;
        step(4);
        debug_req_i = 1;
        step(1);
        check("race_clock_en", 32'(clock_en_o), 32'd1);
        check("race_core_sleep", 32'(core_sleep_o), 32'd0);
        debug_req_i = 0;
        sleep_req_i = 0;
        step(1);
        $display("race: clock_en=%0b", clock_en_o);

        // Test mode holds drain; dropping it sleeps at once from the saturated count
        do_reset();
        test_en_i = 1;
        sleep_req_i = 1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("test_mode_clock_en", 32'(clock_en_o), 32'd1);
        end
        test_en_i = 0;
        step(1);
        check("test_exit_clock_en", 32'(clock_en_o), 32'd0);
        $display("test mode: 50 cycles held, clock_en=%0b after exit", clock_en_o);

        // Asynchronous reset mid-sleep
        step(3);
        #2;
        rst_ni = 0;
        #1;
        check("async_rst_clock_en", 32'(clock_en_o), 32'd1);
        check("async_rst_core_sleep", 32'(core_sleep_o), 32'd0);
        step(1);
        rst_ni = 1;
        $display("async reset mid-sleep: clock_en=%0b", clock_en_o);

`ifdef FLEXBEX_SLEEP_STATS_EN
        do_reset();
        sleep_req_i = 1;
        step(15);
        check("stats_10_cycles", sleep_cycles_o, 32'd10);
        $display("stats: sleep_cycles=%0d", sleep_cycles_o);
`endif

        // Randomized traffic with occasional asynchronous reset pulses
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) sleep_req_i = ~sleep_req_i;
            core_busy_i   = ($urandom_range(0, 9) < 3);
            irq_pending_i = ($urandom_range(0, 59) == 0);
            debug_req_i   = ($urandom_range(0, 99) == 0);
            if (c % 250 == 0) test_en_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst_ni = 0;
                #1;
                check("rand_async_rst_clock_en", 32'(clock_en_o), 32'd1);
                step(1);
                rst_ni = 1;
            end else begin
                step(1);
            end
        end
        $display("random: 4000 cycles driven");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
